// File: rtl/calc_entry_fsm_if.sv
// Switch/button inputs and LCD-controller-facing outputs of the calculator
// entry sequencer. The board-side driver is the master, and the sequencer is the slave.
interface calc_entry_fsm_if;
  logic [8:0] sw;
  logic [1:0] op_sel;
  logic       btn_enter;
  logic       btn_clear;
  logic       btn_power;
  logic [8:0] numberA;
  logic [8:0] numberB;
  logic [3:0] op;
  logic       screen;
  logic [2:0] state_dbg;

  modport master (
    output sw, op_sel, btn_enter, btn_clear, btn_power,
    input  numberA, numberB, op, screen, state_dbg
  );

  modport slave (
    input  sw, op_sel, btn_enter, btn_clear, btn_power,
    output numberA, numberB, op, screen, state_dbg
  );
endinterface

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry sequencer for the calculator LCD controller.
// It synchronises the raw switches and buttons and debounces the buttons into
// one-clock press pulses. It then steps the user through A, operator, B and result.
module calc_entry_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic            clk,
  input  logic            rst,
  calc_entry_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ENTER_A  = 3'd1,
    ENTER_OP = 3'd2,
    ENTER_B  = 3'd3,
    SHOW_RES = 3'd4
  } state_t;

  localparam logic [31:0] LAST = 32'(DEBOUNCE_CYCLES - 1);

  // Button index within the packed button vectors.
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;
  localparam int BTN_POWER = 2;

  logic [8:0]  sw_p0, sw_p1;
  logic [1:0]  op_sel_p0, op_sel_p1;
  logic [2:0]  btn_p0, btn_p1;

  logic [31:0] cnt [3];
  logic [2:0]  level;
  logic [2:0]  armed;
  logic [2:0]  press;

  state_t      state;
  logic [8:0]  number_a;
  logic [8:0]  number_b;
  logic [3:0]  op_r;
  logic        screen_r;

  // -0 is never presented to the LCD controller; it is shown as +0.
  function automatic logic [8:0] normalise(input logic [8:0] v);
    return {v[8] & (v[7:0] != 8'd0), v[7:0]};
  endfunction

  // Two-flop synchronisers. The button flops reset high, so a button that is still
  // held during reset looks pressed. The debouncer then needs to see a release
  // before it can produce a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_p0     <= '0;
      sw_p1     <= '0;
      op_sel_p0 <= '0;
      op_sel_p1 <= '0;
      btn_p0    <= 3'b111;
      btn_p1    <= 3'b111;
    end else begin
      sw_p0     <= bus.sw;
      sw_p1     <= sw_p0;
      op_sel_p0 <= bus.op_sel;
      op_sel_p1 <= op_sel_p0;
      btn_p0    <= {bus.btn_power, bus.btn_clear, bus.btn_enter};
      btn_p1    <= btn_p0;
    end
  end

  // Per-button debouncer. The accepted level flips once the synced level has
  // disagreed with it for DEBOUNCE_CYCLES clocks. Only a rising flip emits a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      level <= '0;
      armed <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (!armed[i]) begin
          cnt[i]   <= '0;
          level[i] <= 1'b0;
          if (!btn_p1[i]) armed[i] <= 1'b1;
        end else if (btn_p1[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i]   <= '0;
          level[i] <= btn_p1[i];
          press[i] <= btn_p1[i];
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end
      end
    end
  end

  // Entry sequencer with registered outputs. Power beats clear, and clear beats enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      number_a <= '0;
      number_b <= '0;
      op_r     <= '0;
      screen_r <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          screen_r <= 1'b0;
          number_a <= '0;
          number_b <= '0;
          op_r     <= '0;
          if (press[BTN_POWER]) begin
            state    <= ENTER_A;
            screen_r <= 1'b1;
          end
        end
        ENTER_A, ENTER_OP, ENTER_B, SHOW_RES: begin
          if (press[BTN_POWER]) begin
            state    <= OFF;
            screen_r <= 1'b0;
            number_a <= '0;
            number_b <= '0;
            op_r     <= '0;
          end else if (press[BTN_CLEAR]) begin
            state    <= ENTER_A;
            screen_r <= 1'b1;
            number_a <= '0;
            number_b <= '0;
            op_r     <= '0;
          end else begin
            screen_r <= 1'b1;
            case (state)
              ENTER_A: begin
                number_b <= '0;
                op_r     <= '0;
                if (press[BTN_ENTER]) state <= ENTER_OP;
                else                  number_a <= normalise(sw_p1);
              end
              ENTER_OP: begin
                op_r <= {2'b00, op_sel_p1};
                if (press[BTN_ENTER] && (op_sel_p1 != 2'd0)) state <= ENTER_B;
              end
              ENTER_B: begin
                if (press[BTN_ENTER]) state <= SHOW_RES;
                else                  number_b <= normalise(sw_p1);
              end
              SHOW_RES: begin
                if (press[BTN_ENTER]) begin
                  state    <= ENTER_A;
                  number_b <= '0;
                  op_r     <= '0;
                end
              end
              default: state <= OFF;
            endcase
          end
        end
        default: begin
          state    <= OFF;
          screen_r <= 1'b0;
          number_a <= '0;
          number_b <= '0;
          op_r     <= '0;
        end
      endcase
    end
  end

  assign bus.numberA   = number_a;
  assign bus.numberB   = number_b;
  assign bus.op        = op_r;
  assign bus.screen    = screen_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed and randomised bench for the calculator entry sequencer.
module tb_calc_entry_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_entry_fsm_if bus ();

  calc_entry_fsm #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: user-visible mode plus the values frozen by earlier presses.
  int         m_state;
  logic [8:0] m_a;
  logic [8:0] m_b;
  logic [3:0] m_op;

  function automatic logic [8:0] nrm(input logic [8:0] v);
    if (v[7:0] == 8'd0) return 9'h000;
    return v;
  endfunction

  function automatic logic [8:0] rand_val();
    logic [8:0] r;
    r = 9'($urandom);
    if ($urandom_range(0, 3) == 0) r[7:0] = 8'd0;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [8:0] ea, eb;
    logic [3:0] eo;
    ea = (m_state == 1) ? nrm(bus.sw) : m_a;
    eb = (m_state == 3) ? nrm(bus.sw) : m_b;
    eo = (m_state == 2) ? {2'b00, bus.op_sel} : m_op;
    check({tag, ".state"},  32'(bus.state_dbg), 32'(m_state));
    check({tag, ".screen"}, 32'(bus.screen),    32'(m_state != 0));
    check({tag, ".A"},      32'(bus.numberA),   32'(ea));
    check({tag, ".B"},      32'(bus.numberB),   32'(eb));
    check({tag, ".op"},     32'(bus.op),        32'(eo));
  endtask

  task automatic model_press(input bit p_enter, input bit p_clear, input bit p_power);
    if (m_state == 1) m_a = nrm(bus.sw);
    if (m_state == 2) m_op = {2'b00, bus.op_sel};
    if (m_state == 3) m_b = nrm(bus.sw);
    if (p_power) begin
      m_state = (m_state == 0) ? 1 : 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else if (m_state != 0 && p_clear) begin
      m_state = 1;
      m_a = '0; m_b = '0; m_op = '0;
    end else if (m_state != 0 && p_enter) begin
      case (m_state)
        1: m_state = 2;
        2: if (bus.op_sel != 2'd0) m_state = 3;
        3: m_state = 4;
        4: begin m_state = 1; m_b = '0; m_op = '0; end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic press(input bit p_enter, input bit p_clear, input bit p_power);
    model_press(p_enter, p_clear, p_power);
    bus.btn_enter = p_enter;
    bus.btn_clear = p_clear;
    bus.btn_power = p_power;
    cyc(8);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_power = 1'b0;
    cyc(8);
  endtask

  task automatic set_sw(input logic [8:0] v);
    bus.sw = v;
    cyc(4);
  endtask

  task automatic set_op(input logic [1:0] v);
    bus.op_sel = v;
    cyc(4);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] o;
    rst = 1'b1;
    bus.sw = '0; bus.op_sel = '0;
    bus.btn_enter = 1'b0; bus.btn_clear = 1'b0; bus.btn_power = 1'b0;
    m_state = 0; m_a = '0; m_b = '0; m_op = '0;
    cyc(3);
    check_model("reset");
    rst = 1'b0;
    cyc(4);
    check_model("idle_off");

    // Enter and clear do nothing while off.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_model("off_ignores");

    press(1'b0, 1'b0, 1'b1);
    check_model("power_on");

    // A switch change reaches numberA on the third clock edge.
    bus.sw = 9'h105;
    cyc(2);
    check("latency_2clk", 32'(bus.numberA), 32'h000);
    cyc(1);
    check("latency_3clk", 32'(bus.numberA), 32'h105);

    // Bouncing enter then a steady hold gives exactly one advance.
    model_press(1'b1, 1'b0, 1'b0);
    bus.btn_enter = 1'b1; cyc(1);
    bus.btn_enter = 1'b0; cyc(1);
    bus.btn_enter = 1'b1; cyc(1);
    bus.btn_enter = 1'b0; cyc(1);
    bus.btn_enter = 1'b1; cyc(10);
    bus.btn_enter = 1'b0; cyc(10);
    check_model("bounce");
    check("bounce_state", 32'(bus.state_dbg), 32'd2);

    // Enter with no operator selected is ignored.
    set_op(2'd0);
    press(1'b1, 1'b0, 1'b0);
    check_model("op_none_guard");

    // Full directed sequence starting from a cleared entry.
    press(1'b0, 1'b1, 1'b0);
    check_model("clear");
    set_sw(9'h10C);
    press(1'b1, 1'b0, 1'b0);
    set_op(2'd2);
    press(1'b1, 1'b0, 1'b0);
    set_sw(9'h007);
    press(1'b1, 1'b0, 1'b0);
    check("seq_A",     32'(bus.numberA),   32'h10C);
    check("seq_op",    32'(bus.op),        32'h2);
    check("seq_B",     32'(bus.numberB),   32'h007);
    check("seq_state", 32'(bus.state_dbg), 32'd4);
    set_sw(9'h0FF);
    set_op(2'd1);
    check_model("seq_frozen");

    // Negative zero is shown as +0.
    press(1'b1, 1'b0, 1'b0);
    set_sw(9'h100);
    check("neg_zero", 32'(bus.numberA), 32'h000);
    check_model("neg_zero_model");

    // Power and enter pressed together in ENTER_B: power wins, and enter is lost.
    set_sw(9'h033);
    press(1'b1, 1'b0, 1'b0);
    set_op(2'd3);
    press(1'b1, 1'b0, 1'b0);
    check_model("in_enter_b");
    press(1'b1, 1'b0, 1'b1);
    check_model("power_beats_enter");
    cyc(20);
    check_model("enter_dropped");

    // Randomised full sequences, with occasional clear presses mixed in.
    press(1'b0, 1'b0, 1'b1);
    for (int it = 0; it < 6; it++) begin
      set_sw(rand_val());
      check_model("rnd_trackA");
      press(1'b1, 1'b0, 1'b0);
      o = 2'($urandom_range(0, 3));
      set_op(o);
      check_model("rnd_trackOp");
      press(1'b1, 1'b0, 1'b0);
      if (o == 2'd0) begin
        check_model("rnd_op0");
        set_op(2'($urandom_range(1, 3)));
        press(1'b1, 1'b0, 1'b0);
      end
      set_sw(rand_val());
      check_model("rnd_trackB");
      if ($urandom_range(0, 3) == 0) begin
        press(1'b0, 1'b1, 1'b1 == 1'b0);
        check_model("rnd_clear");
        continue;
      end
      press(1'b1, 1'b0, 1'b0);
      set_sw(rand_val());
      check_model("rnd_result");
      press(1'b1, 1'b0, 1'b0);
      check_model("rnd_back_to_A");
    end

    // Asynchronous reset between clock edges while showing a result.
    press(1'b0, 1'b1, 1'b0);
    set_sw(9'h081);
    press(1'b1, 1'b0, 1'b0);
    set_op(2'd1);
    press(1'b1, 1'b0, 1'b0);
    set_sw(9'h1F0);
    press(1'b1, 1'b0, 1'b0);
    check_model("pre_async");
    #2;
    rst = 1'b1;
    #1;
    m_state = 0; m_a = '0; m_b = '0; m_op = '0;
    check_model("async_reset");

    // A button that is held through reset must be released before it counts.
    bus.btn_power = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(14);
    check_model("held_through_reset");
    bus.btn_power = 1'b0;
    cyc(8);
    check_model("held_released");
    press(1'b0, 1'b0, 1'b1);
    check_model("repress_power");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
